data_integrity_checker: RTL and testbench

- Downstream consumer of the data-integrity scoreboard.
- Captures the "magic" data word on the first push at or after `start`.
- Watches the FIFO read side and, on the pop the scoreboard marks valid (`data_out_vld`), compares the popped word against the captured word.
- Reports sticky pass/fail, the capture-to-check latency in cycles and, optionally, a watchdog timeout. These give the bench and formal harness a single registered verdict.

---
 rtl/data_integrity_checker_pkg.sv | 15 +
 rtl/data_integrity_checker_if.sv | 27 ++
 rtl/data_integrity_checker_sat_counter.sv | 27 ++
 rtl/data_integrity_checker.sv | 95 +++++++++
 tb/tb_data_integrity_checker.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/data_integrity_checker_pkg.sv
// Shared types and default widths for the data-integrity checker and the scoreboard bench.
package data_integrity_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PUSH = 3'd1,
    WAIT_POP  = 3'd2,
    PASS      = 3'd3,
    FAIL      = 3'd4
  } dic_state_t;

  localparam int DIC_WIDTH = 8;
  localparam int DIC_LAT_W = 5;

endpackage

// File: rtl/data_integrity_checker_if.sv
// FIFO-side strobes, data and verdict outputs of the data-integrity checker.
interface data_integrity_checker_if #(
  parameter int WIDTH = 8,
  parameter int LAT_W = 5
);
  logic             start;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_out_vld;
  logic             check_done;
  logic             check_pass;
  logic             check_fail;
  logic             timeout;
  logic [LAT_W-1:0] latency;

  modport master (
    output start, push, pop, data_in, data_out, data_out_vld,
    input  check_done, check_pass, check_fail, timeout, latency
  );

  modport slave (
    input  start, push, pop, data_in, data_out, data_out_vld,
    output check_done, check_pass, check_fail, timeout, latency
  );
endinterface

// File: rtl/data_integrity_checker_sat_counter.sv
// Up-counter with synchronous clear that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 5
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && (count_q != {W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/data_integrity_checker.sv
// Captures the magic word on the first armed push and checks it on the scoreboard-flagged pop.
// Optional watchdog in WAIT_POP is enabled with the DIC_TIMEOUT_EN macro.
module data_integrity_checker
  import data_integrity_pkg::*;
#(
  parameter int WIDTH   = DIC_WIDTH,
  parameter int LAT_W   = DIC_LAT_W,
  parameter int TIMEOUT = 16
) (
  input logic                      CLK,
  input logic                      rst,
  data_integrity_checker_if.slave  bus
);
  if ((TIMEOUT < 1) || (TIMEOUT > (2**LAT_W) - 1)) begin : g_bad_timeout
    $error("TIMEOUT must lie in 1 .. 2**LAT_W-1");
  end

  dic_state_t       state_q, state_d;
  logic [WIDTH-1:0] magic_q, magic_d;
  logic             timeout_q, timeout_d;
  logic             cnt_clr, cnt_inc;
  logic [LAT_W-1:0] cnt;

`ifdef DIC_TIMEOUT_EN
  localparam logic [LAT_W-1:0] TO_CNT = LAT_W'(TIMEOUT);
  logic [LAT_W-1:0] cnt_nxt;
  assign cnt_nxt = (cnt == {LAT_W{1'b1}}) ? cnt : cnt + 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    magic_d   = magic_q;
    timeout_d = timeout_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && bus.push) begin
          magic_d = bus.data_in;
          cnt_clr = 1'b1;
          state_d = WAIT_POP;
        end else if (bus.start) begin
          state_d = WAIT_PUSH;
        end
      end
      WAIT_PUSH: begin
        if (bus.push) begin
          magic_d = bus.data_in;
          cnt_clr = 1'b1;
          state_d = WAIT_POP;
        end
      end
      WAIT_POP: begin
        // Counting continues through the verdict cycle so latency includes that edge.
        cnt_inc = 1'b1;
        if (bus.pop && bus.data_out_vld) begin
          state_d = (bus.data_out == magic_q) ? PASS : FAIL;
        end
`ifdef DIC_TIMEOUT_EN
        else if (cnt_nxt == TO_CNT) begin
          state_d   = FAIL;
          timeout_d = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      magic_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      magic_q   <= magic_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.W(LAT_W)) u_lat_cnt (
    .CLK   (CLK),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt)
  );

  assign bus.check_done = (state_q == PASS) || (state_q == FAIL);
  assign bus.check_pass = (state_q == PASS);
  assign bus.check_fail = (state_q == FAIL);
  assign bus.timeout    = timeout_q;
  assign bus.latency    = cnt;
endmodule

// File: tb/tb_data_integrity_checker.sv
// Directed bench for data_integrity_checker; build with DIC_TIMEOUT_EN to exercise the watchdog.
module tb_data_integrity_checker;
  logic CLK = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  data_integrity_checker_if #(.WIDTH(8), .LAT_W(5)) bus ();

  data_integrity_checker #(.WIDTH(8), .LAT_W(5), .TIMEOUT(4)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic pu, input logic po,
                       input logic [7:0] din, input logic [7:0] dout, input logic vld);
    bus.start        = st;
    bus.push         = pu;
    bus.pop          = po;
    bus.data_in      = din;
    bus.data_out     = dout;
    bus.data_out_vld = vld;
  endtask

  // Inputs change on the falling edge; outputs are read there too, after the rising edge settled.
  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc(n);
  endtask

  task automatic verdict(input string tag, input logic d, input logic p, input logic f,
                         input logic t, input logic [4:0] lat);
    chk({tag, ".done"},    32'(bus.check_done), 32'(d));
    chk({tag, ".pass"},    32'(bus.check_pass), 32'(p));
    chk({tag, ".fail"},    32'(bus.check_fail), 32'(f));
    chk({tag, ".timeout"}, 32'(bus.timeout),    32'(t));
    chk({tag, ".latency"}, 32'(bus.latency),    32'(lat));
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    rst = 1'b0;
    #1;
    verdict(tag, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    idle(1);
    rst = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc(2);
    verdict("reset", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    rst = 1'b1;

    // A valid pop while unarmed must not be compared (captured word is 0 here).
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
    cyc(2);
    chk("idle_pop.done", 32'(bus.check_done), 32'd0);

    // Test 1: capture 0xA5, two idle cycles, matching pop -> latency 3.
    drive(1'b1, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0); cyc(1);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'hA5, 1'b1); cyc(1);
    verdict("t1", 1'b1, 1'b1, 1'b0, 1'b0, 5'd3);

    // Terminal state ignores a fresh capture and a mismatching pop.
    drive(1'b1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0); cyc(1);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1); cyc(3);
    verdict("frozen", 1'b1, 1'b1, 1'b0, 1'b0, 5'd3);

    do_reset("rst1");

    // Test 2: start alone, push 0x3C two cycles later, mismatching pop 0x3D.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0); cyc(1);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0); cyc(1);
    chk("t2.wait_push", 32'(bus.check_done), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0); cyc(1);
    idle(1);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h3D, 1'b1); cyc(1);
    verdict("t2", 1'b1, 1'b0, 1'b1, 1'b0, 5'd2);

    do_reset("rst2");

    // Test 3: capture 0x11, five unflagged pops with pushes of other data, then a valid pop.
    drive(1'b1, 1'b1, 1'b0, 8'h11, 8'h00, 1'b0); cyc(1);
    drive(1'b0, 1'b1, 1'b1, 8'h22, 8'h11, 1'b0); cyc(5);
    verdict("t3.mid", 1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 1'b1); cyc(1);
    verdict("t3", 1'b1, 1'b1, 1'b0, 1'b0, 5'd6);

    do_reset("rst3");

`ifdef DIC_TIMEOUT_EN
    drive(1'b1, 1'b1, 1'b0, 8'h42, 8'h00, 1'b0); cyc(1);
    idle(3);
    verdict("to.mid", 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
    idle(1);
    verdict("to.fire", 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
    idle(3);
    verdict("to.hold", 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
    do_reset("rst_to");
    drive(1'b1, 1'b1, 1'b0, 8'h42, 8'h00, 1'b0); cyc(1);
    idle(3);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h42, 1'b1); cyc(1);
    verdict("to.race", 1'b1, 1'b1, 1'b0, 1'b0, 5'd4);
`else
    drive(1'b1, 1'b1, 1'b0, 8'h42, 8'h00, 1'b0); cyc(1);
    idle(20);
    verdict("nto.mid", 1'b0, 1'b0, 1'b0, 1'b0, 5'd20);
    idle(20);
    verdict("nto.sat", 1'b0, 1'b0, 1'b0, 1'b0, 5'd31);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h42, 1'b1); cyc(1);
    verdict("nto.pass", 1'b1, 1'b1, 1'b0, 1'b0, 5'd31);
`endif

    do_reset("rst4");

    // Reset in WAIT_POP, then a fresh check with a pop right after capture.
    drive(1'b1, 1'b1, 1'b0, 8'h77, 8'h00, 1'b0); cyc(1);
    idle(2);
    do_reset("rst_mid");
    drive(1'b1, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b0); cyc(1);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h5A, 1'b1); cyc(1);
    verdict("t5", 1'b1, 1'b1, 1'b0, 1'b0, 5'd1);

    idle(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
